// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encodings and BCD digit constants for countdown_timer
package timer_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Preset digits above 9 are not valid BCD; saturate them.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/countdown_tick.sv
// rtl/countdown_tick.sv - one-second prescaler; counts while enabled, holds its count while disabled
module countdown_tick
  import timer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_FREQUENCY - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);
  assign o_tick = i_enable && w_last;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - two-digit BCD countdown timer; optional Warn output under COUNTDOWN_WARN_EN
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int START_SECONDS   = 60
) (
  input  logic               ClockIn,
  input  logic               Reset,
  input  logic               Load,
  input  logic [DIGIT_W-1:0] LoadTens,
  input  logic [DIGIT_W-1:0] LoadOnes,
  input  logic               Start,
  input  logic               Pause,
  output logic [DIGIT_W-1:0] TensValue,
  output logic [DIGIT_W-1:0] OnesValue,
  output logic               Running,
  output logic               TimeUp,
  output logic               Expired,
  output logic               Warn
);

  localparam logic [DIGIT_W-1:0] RESET_TENS = DIGIT_W'(START_SECONDS / 10);
  localparam logic [DIGIT_W-1:0] RESET_ONES = DIGIT_W'(START_SECONDS % 10);

  state_t             r_state, w_next_state;
  logic [DIGIT_W-1:0] r_tens, r_ones, w_next_tens, w_next_ones;
  logic               r_running, r_time_up, r_expired;
  logic               w_time_up_next, w_start_ok, w_clear, w_enable, w_tick;

  assign w_start_ok = Start && (r_state == S_IDLE) && ((r_tens != '0) || (r_ones != '0));
  assign w_clear    = Load || w_start_ok;
  // Pause holds the prescaler, so a tick due this cycle is carried to the next RUN cycle.
  assign w_enable   = (r_state == S_RUN) && !Load && !Pause;

  countdown_tick #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
  ) u_tick (
    .i_clk   (ClockIn),
    .i_reset (Reset),
    .i_clear (w_clear),
    .i_enable(w_enable),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_next_state   = r_state;
    w_next_tens    = r_tens;
    w_next_ones    = r_ones;
    w_time_up_next = 1'b0;
    if (Load) begin
      w_next_tens  = clamp_digit(LoadTens);
      w_next_ones  = clamp_digit(LoadOnes);
      w_next_state = S_IDLE;
    end else if (w_start_ok) begin
      w_next_state = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (Pause) begin
            w_next_state = S_PAUSED;
          end else if (w_tick) begin
            if (r_ones == '0) begin
              w_next_ones = DIGIT_MAX;
              w_next_tens = r_tens - 1'b1;
            end else begin
              w_next_ones = r_ones - 1'b1;
            end
            if ((r_tens == '0) && (r_ones == 4'd1)) begin
              w_next_state   = S_DONE;
              w_time_up_next = 1'b1;
            end
          end
        end
        S_PAUSED: if (!Pause) w_next_state = S_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_tens    <= RESET_TENS;
      r_ones    <= RESET_ONES;
      r_running <= 1'b0;
      r_time_up <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_tens    <= w_next_tens;
      r_ones    <= w_next_ones;
      r_running <= (w_next_state == S_RUN);
      r_time_up <= w_time_up_next;
      r_expired <= (w_next_state == S_DONE);
    end
  end

  assign TensValue = r_tens;
  assign OnesValue = r_ones;
  assign Running   = r_running;
  assign TimeUp    = r_time_up;
  assign Expired   = r_expired;

`ifdef COUNTDOWN_WARN_EN
  logic r_warn, w_warn_next;

  always_comb begin
    w_warn_next = ((w_next_state == S_RUN) || (w_next_state == S_PAUSED)) &&
                  ((w_next_tens == '0) || ((w_next_tens == 4'd1) && (w_next_ones == '0)));
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) r_warn <= 1'b0;
    else       r_warn <= w_warn_next;
  end

  assign Warn = r_warn;
`else
  assign Warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer with a 4-cycle second
module tb_countdown_timer;

  localparam int CF = 4;
`ifdef COUNTDOWN_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic       ClockIn = 1'b0;
  logic       Reset = 1'b1, Load = 1'b0, Start = 1'b0, Pause = 1'b0;
  logic [3:0] LoadTens = 4'd0, LoadOnes = 4'd0;
  logic [3:0] TensValue, OnesValue;
  logic       Running, TimeUp, Expired, Warn;

  int errors = 0;
  int checks = 0;
  int tu_count = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
    logic [3:0] flags;
  } exp_t;
  exp_t sb[$];

  always #5 ClockIn = ~ClockIn;

  countdown_timer #(
    .CLOCK_FREQUENCY(CF),
    .START_SECONDS  (60)
  ) dut (
    .ClockIn  (ClockIn),
    .Reset    (Reset),
    .Load     (Load),
    .LoadTens (LoadTens),
    .LoadOnes (LoadOnes),
    .Start    (Start),
    .Pause    (Pause),
    .TensValue(TensValue),
    .OnesValue(OnesValue),
    .Running  (Running),
    .TimeUp   (TimeUp),
    .Expired  (Expired),
    .Warn     (Warn)
  );

  task automatic tick1();
    @(posedge ClockIn);
    #1;
    if (TimeUp === 1'b1) tu_count++;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick1();
  endtask

  // act = state is RUN or PAUSED (Warn qualifies on both)
  task automatic expect_out(input string tag, input int n, input logic run, input logic act,
                            input logic tu, input logic ex);
    exp_t e;
    e.tag   = tag;
    e.val   = {4'(n / 10), 4'(n % 10)};
    e.flags = {run, tu, ex, WARN_ON && act && (n <= 10)};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [11:0] obs, expv;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed=0 entries required>=1");
      return;
    end
    e    = sb.pop_front();
    obs  = {TensValue, OnesValue, Running, TimeUp, Expired, Warn};
    expv = {e.val, e.flags};
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h required=%h (tens,ones,run,timeup,expired,warn)", e.tag, obs, expv);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d required=%0d", tag, obs, expv);
    end
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    Load = 1'b1; LoadTens = t; LoadOnes = o;
    tick1();
    Load = 1'b0;
  endtask

  task automatic do_start();
    Start = 1'b1;
    tick1();
    Start = 1'b0;
  endtask

  initial begin
    int n;
    int tu0;

    // reset state
    cycles(2);
    expect_out("reset", 60, 0, 0, 0, 0);
    check_out();
    Reset = 1'b0;

    // full countdown from 60
    tu0 = tu_count;
    do_start();
    expect_out("start60", 60, 1, 1, 0, 0); check_out();
    cycles(CF - 1);
    expect_out("pre_first_tick", 60, 1, 1, 0, 0); check_out();
    tick1();
    expect_out("first_tick", 59, 1, 1, 0, 0); check_out();
    for (int i = 2; i <= 59; i++) begin
      cycles(CF);
      expect_out($sformatf("count_%0d", 60 - i), 60 - i, 1, 1, 0, 0);
      check_out();
    end
    n = 0;
    while (TimeUp !== 1'b1 && n < 3 * CF) begin
      tick1();
      n++;
    end
    chk("timeup_latency", n, CF);
    expect_out("reach_00", 0, 0, 0, 1, 1); check_out();
    tick1();
    expect_out("timeup_one_cycle", 0, 0, 0, 0, 1); check_out();
    do_start();
    cycles(5);
    expect_out("done_holds", 0, 0, 0, 0, 1); check_out();
    chk("timeup_count_60", tu_count - tu0, 1);

    // borrow across tens
    do_load(4'd1, 4'd0);
    expect_out("load10", 10, 0, 0, 0, 0); check_out();
    do_start();
    cycles(CF);
    expect_out("borrow_09", 9, 1, 1, 0, 0); check_out();
    cycles(CF);
    expect_out("borrow_08", 8, 1, 1, 0, 0); check_out();

    // pause for 7 cycles mid-interval
    do_load(4'd2, 4'd5);
    do_start();
    tick1();
    Pause = 1'b1;
    tick1();
    expect_out("paused", 25, 0, 1, 0, 0); check_out();
    cycles(6);
    expect_out("paused_frozen", 25, 0, 1, 0, 0); check_out();
    Pause = 1'b0;
    tick1();
    expect_out("resumed", 25, 1, 1, 0, 0); check_out();
    cycles(CF - 2);
    expect_out("resume_pre_tick", 25, 1, 1, 0, 0); check_out();
    tick1();
    expect_out("resume_tick", 24, 1, 1, 0, 0); check_out();
    cycles(CF);
    expect_out("tick_23", 23, 1, 1, 0, 0); check_out();

    // pause arriving exactly when a tick is due
    cycles(CF - 1);
    Pause = 1'b1;
    tick1();
    expect_out("tick_suppressed", 23, 0, 1, 0, 0); check_out();
    Pause = 1'b0;
    tick1();
    expect_out("resume_no_tick", 23, 1, 1, 0, 0); check_out();
    tick1();
    expect_out("tick_delivered", 22, 1, 1, 0, 0); check_out();

    // Load mid-RUN goes IDLE and clears the prescaler
    do_load(4'd4, 4'd2);
    expect_out("load_mid_run", 42, 0, 0, 0, 0); check_out();
    do_start();
    cycles(CF - 1);
    expect_out("prescaler_cleared", 42, 1, 1, 0, 0); check_out();
    tick1();
    expect_out("tick_41", 41, 1, 1, 0, 0); check_out();

    // clamped load and Start at 00
    do_load(4'hF, 4'hA);
    expect_out("clamp_99", 99, 0, 0, 0, 0); check_out();
    do_load(4'd0, 4'd0);
    tu0 = tu_count;
    do_start();
    expect_out("start_00_ignored", 0, 0, 0, 0, 0); check_out();
    cycles(2 * CF);
    expect_out("still_idle_00", 0, 0, 0, 0, 0); check_out();
    chk("no_timeup_00", tu_count - tu0, 0);

    // Reset during RUN at 05
    do_load(4'd0, 4'd5);
    do_start();
    cycles(2);
    tu0 = tu_count;
    Reset = 1'b1;
    tick1();
    Reset = 1'b0;
    expect_out("reset_mid_run", 60, 0, 0, 0, 0); check_out();
    cycles(6 * CF);
    expect_out("reset_stays_idle", 60, 0, 0, 0, 0); check_out();
    chk("no_timeup_reset", tu_count - tu0, 0);

    // Load and Start together: Load wins
    Load = 1'b1; Start = 1'b1; LoadTens = 4'd0; LoadOnes = 4'd3;
    tick1();
    Load = 1'b0; Start = 1'b0;
    expect_out("load_beats_start", 3, 0, 0, 0, 0); check_out();
    cycles(5);
    expect_out("load_start_idle", 3, 0, 0, 0, 0); check_out();

    // countdown from 12 (exercises Warn when enabled)
    do_load(4'd1, 4'd2);
    do_start();
    expect_out("start12", 12, 1, 1, 0, 0); check_out();
    for (int v = 11; v >= 1; v--) begin
      cycles(CF);
      expect_out($sformatf("warn_%0d", v), v, 1, 1, 0, 0);
      check_out();
    end
    cycles(CF);
    expect_out("warn_done", 0, 0, 0, 1, 1); check_out();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, clock cycles per one-second tick.
REQ-002 SHALL have parameter START_SECONDS, default 60, the reset/preset time; legal range 0..99.
REQ-003 SHALL have port ClockIn, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port Load, input, 1, a one-cycle request to preset the time from LoadTens/LoadOnes.
REQ-006 SHALL have ports LoadTens and LoadOnes, input, 4 each, the BCD preset digits.
REQ-007 SHALL have port Start, input, 1, a one-cycle request to begin counting.
REQ-008 SHALL have port Pause, input, 1, a level that holds the count while high.
REQ-009 SHALL have ports TensValue and OnesValue, output, 4 each, the BCD time remaining for the hex decoders.
REQ-010 SHALL have port Running, output, 1, high in RUN state.
REQ-011 SHALL have ports TimeUp, output, 1 (one-cycle pulse), and Expired, output, 1 (level high in DONE).
REQ-012 SHALL have port Warn, output, 1, the low-time indication (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSED, DONE.
REQ-014 SHALL apply input priority Reset > Load > Start > Pause in any cycle.
REQ-015 SHALL, on Load in any state, register the digits next cycle, clamping any digit >9 to 9, clear the prescaler and go to IDLE.
REQ-016 SHALL, on Start in IDLE with a nonzero value, go to RUN and clear the prescaler; Start with 00 SHALL be ignored.
REQ-017 SHALL ignore Start in RUN, PAUSED and DONE.
REQ-018 SHALL emit a one-second tick from the prescaler only in RUN, exactly CLOCK_FREQUENCY cycles after entering RUN from IDLE, then every CLOCK_FREQUENCY cycles.
REQ-019 SHALL decrement by one in BCD on each tick: if Ones is 0, Ones becomes 9 and Tens decrements; otherwise Ones decrements.
REQ-020 SHALL, on the tick that reaches 00, enter DONE and assert TimeUp for exactly the cycle in which the outputs first read 00.
REQ-021 SHALL move RUN to PAUSED while Pause is high and PAUSED to RUN when Pause is low; the prescaler count SHALL be frozen (not cleared) while paused.
REQ-022 SHALL, if Pause rises in the same cycle a tick is due, suppress that tick and deliver it on the first RUN cycle after resume.
REQ-023 SHALL hold DONE with the value at 00 until Load or Reset arrives.
REQ-024 SHALL register all outputs, with no combinational path from an input to an output.

Reset
REQ-025 SHALL, on Reset, set state IDLE, TensValue = START_SECONDS/10, OnesValue = START_SECONDS%10, prescaler 0, and Running, TimeUp, Expired and Warn to 0.
REQ-026 SHALL have Reset mid-RUN or mid-PAUSED abort the countdown with no TimeUp pulse.

Configuration
REQ-027 SHALL provide macro COUNTDOWN_WARN_EN; when defined, Warn is high whenever the state is RUN or PAUSED and the value is 10 or less, and low otherwise.
REQ-028 SHALL, without COUNTDOWN_WARN_EN, tie Warn to constant 0 and omit its comparison logic.

Structure
REQ-029 SHALL place the FSM state encodings, the BCD digit width (4) and the digit constant 9 in the shared package timer_pkg.
REQ-030 SHALL implement the prescaler as sub-module countdown_tick (inputs: clear, enable; output: tick), sized with $clog2(CLOCK_FREQUENCY).

Verification (CLOCK_FREQUENCY=4 unless stated)
REQ-031 SHALL cover reset-then-Start with default 60: first tick 4 cycles after Start gives 59; 60 ticks later the value is 00, TimeUp is one cycle wide and Expired stays high.
REQ-032 SHALL cover borrow across tens: Load 10 then Start gives 09 after the first tick and 08 after the second.
REQ-033 SHALL cover Pause high for 7 cycles mid-interval: the value is frozen and the next tick arrives exactly at the remaining prescaler count after Pause falls.
REQ-034 SHALL cover Load 0xF/0xA: the value reads 99; Load 00 followed by Start stays IDLE with no TimeUp.
REQ-035 SHALL cover Reset asserted during RUN at value 05: next cycle reads 60 in IDLE with no TimeUp; Load and Start in the same cycle resolves to Load only.
REQ-036 SHALL cover, with COUNTDOWN_WARN_EN, Start at 12: Warn rises on the tick to 10 and falls on entry to DONE.
